vga_pic_scroll: RTL

Parametrised successor pixel generator for the piano VGA path; vga_ctrl supplies pix_x/pix_y and frame_sync.
- Left 7/10 of the screen: NUM_KEYS key bars with a release afterglow.
- Right 3/10: a song-title bitmap, fetched from an external 1-bit title ROM, scrolled horizontally with wrap-around.
- Output is pipelined two cycles; vga_ctrl delays hsync/vsync by 2 to match.

---
 rtl/vga_pic_scroll_if.sv | 11 +
 rtl/vga_pic_scroll.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vga_pic_scroll_if.sv
// Title ROM bus: the pixel generator drives the address,
// the ROM answers with one bit on the following clock.
interface vga_pic_scroll_if #(
    parameter int AW = 14
);
    logic [AW-1:0] rom_addr;
    logic          rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/vga_pic_scroll.sv
// Piano VGA pixel generator: key bars with release afterglow on the left,
// scrolling song-title bitmap on the right; two-cycle pixel latency.
module vga_pic_scroll #(
    parameter int H_VALID     = 640,
    parameter int V_VALID     = 480,
    parameter int NUM_KEYS    = 7,
    parameter int KEY_X0      = 120,
    parameter int KEY_W       = 40,
    parameter int HOLD_FRAMES = 15,
    parameter int GLYPH_W     = 32,
    parameter int GLYPH_H     = 32,
    parameter int SCROLL_DIV  = 4
) (
    input  logic                vga_clk,
    input  logic                sys_rst_n,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    input  logic                frame_sync,
    input  logic [NUM_KEYS-1:0] status,
    input  logic [3:0]          num,
    input  logic                scroll_en,
    vga_pic_scroll_if.master    rom,
    output logic [11:0]         pix_data
);
    localparam int KEY_END = H_VALID * 7 / 10;
    localparam int GHB = $clog2(GLYPH_H);
    localparam int CB  = $clog2(4 * GLYPH_W);
    localparam int AW  = 2 + GHB + CB;
    localparam int HW  = $clog2(HOLD_FRAMES + 1);
    localparam int DW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    typedef enum logic [2:0] {
        R_BLACK, R_WHITE, R_GRAY, R_CYAN, R_GLYPH
    } region_t;

    logic [HW-1:0] hold [NUM_KEYS];
    logic [3:0]    num_q;
    logic [1:0]    sel;
    logic [CB:0]   tw;
    logic [CB-1:0] off;
    logic [DW-1:0] div;
    logic [9:0]    rx;
    logic [CB:0]   col;
    logic [AW-1:0] addr_d, addr_q;
    region_t       region_d, region_q;
    logic [1:0]    sel_q;

    always_comb begin
        case (num_q)
            4'd1:    sel = 2'd0;
            4'd2:    sel = 2'd1;
            4'd3:    sel = 2'd2;
            default: sel = 2'd3;
        endcase
    end

    assign tw = (sel == 2'd0) ? (CB+1)'(3 * GLYPH_W) : (CB+1)'(4 * GLYPH_W);
    assign rx = pix_x - 10'(KEY_END);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (status[i])
                    hold[i] <= HW'(HOLD_FRAMES);
                else if (frame_sync && hold[i] != '0)
                    hold[i] <= hold[i] - HW'(1);
            end
        end
    end

    // Title selection only moves at frame boundaries so a frame is never torn.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            num_q <= '0;
            off   <= '0;
            div   <= '0;
        end else if (frame_sync) begin
            num_q <= num;
            if (num != num_q) begin
                off <= '0;
                div <= '0;
            end else if (scroll_en) begin
                if (div == DW'(SCROLL_DIV - 1)) begin
                    div <= '0;
                    if ({1'b0, off} == tw - (CB+1)'(1))
                        off <= '0;
                    else
                        off <= off + CB'(1);
                end else begin
                    div <= div + DW'(1);
                end
            end
        end
    end

    always_comb begin
        region_d = R_BLACK;
        addr_d   = addr_q;
        col      = '0;
        if (pix_x >= 10'(H_VALID) || pix_y >= 10'(V_VALID)) begin
            region_d = R_BLACK;
        end else if (pix_x < 10'(KEY_END)) begin
            region_d = R_WHITE;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (pix_x >= 10'(KEY_X0 + i * KEY_W) &&
                    pix_x <  10'(KEY_X0 + (i + 1) * KEY_W)) begin
                    if (i != NUM_KEYS - 1 &&
                        pix_x == 10'(KEY_X0 + (i + 1) * KEY_W - 1))
                        region_d = R_BLACK;
                    else if (status[i])
                        region_d = R_BLACK;
                    else if (hold[i] != '0)
                        region_d = R_GRAY;
                    else
                        region_d = R_WHITE;
                end
            end
        end else if (pix_y < 10'(GLYPH_H) && rx < 10'(tw)) begin
            region_d = R_GLYPH;
            col = {1'b0, rx[CB-1:0]} + {1'b0, off};
            if (col >= tw) col = col - tw;
            addr_d = {sel, pix_y[GHB-1:0], col[CB-1:0]};
        end else begin
            region_d = R_CYAN;
        end
    end

    // Address is presented combinationally so the synchronous ROM answers in stage 2.
    assign rom.rom_addr = addr_d;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_q   <= '0;
            region_q <= R_BLACK;
            sel_q    <= 2'd3;
            pix_data <= 12'h000;
        end else begin
            addr_q   <= addr_d;
            region_q <= region_d;
            sel_q    <= sel;
            case (region_q)
                R_WHITE: pix_data <= 12'hFFF;
                R_GRAY:  pix_data <= 12'h888;
                R_CYAN:  pix_data <= 12'h0FF;
                R_GLYPH: begin
                    if (rom.rom_data)
                        pix_data <= 12'h000;
                    else begin
                        case (sel_q)
                            2'd0:    pix_data <= 12'h0FF;
                            2'd1:    pix_data <= 12'h0F0;
                            2'd2:    pix_data <= 12'h00F;
                            default: pix_data <= 12'hF00;
                        endcase
                    end
                end
                default: pix_data <= 12'h000;
            endcase
        end
    end
endmodule
